divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential 32-bit integer divider for the RISC5 CPU execute stage; radix-2 restoring algorithm, one quotient bit per enabled clock.
- Computes quotient and remainder of x by y, unsigned or signed with floor semantics (non-negative remainder).
- Holds the CPU pipeline via `stall` until the result is ready.

Parameters:
- None. Width is fixed at 32 bits; step count is fixed at 33.

Ports:
- clk   input  1   system clock, rising edge
- rst   input  1   asynchronous, active-low reset
- ce    input  1   clock enable; all state updates only when ce=1
- run   input  1   operation request; held high by CPU for the whole division
- u     input  1   1 = signed dividend, 0 = unsigned
- x     input  32  dividend
- y     input  32  divisor, always treated as unsigned magnitude
- stall output 1   high while a requested division is not yet complete
- quot  output 32  quotient
- rem   output 32  remainder

Behaviour:
- Reset (rst=0, asynchronous):
  - step counter S=0; partial remainder/quotient register RQ (64 bits) = 0.
  - quot=0, rem=0, stall=0 (run must be low during reset).
- Counter S (6 bits):
  - On each enabled edge: if run=1 and S<33, S<=S+1.
  - If run=1 and S=33, S holds at 33 (saturates).
  - If run=0, S<=0.
- stall = run & (S != 33). Combinational; stall is high in the same cycle run rises.
- Dividend preparation: x0 = (u & x[31]) ? -x : x; sign = u & x[31].
- Datapath, per enabled edge while run=1:
  - S=0: RQ <= {32'b0, x0}.
  - 1≤S≤32: let w0 = RQ[62:31] - y (33-bit compare).
    - If w0 ≥ 0 (no borrow): RQ <= {w0[31:0], RQ[30:0], 1}.
    - Otherwise: RQ <= {RQ[62:0], 0}.
  - S=33: RQ holds.
  - run=0: RQ holds its last value and is not cleared.
- Result (combinational from RQ), with r' = RQ[63:32] and q' = RQ[31:0]:
  - sign=0: quot=q', rem=r'.
  - sign=1, r'=0: quot=-q', rem=0.
  - sign=1, r'≠0: quot=-q'-1, rem=y-r'.
- Latency:
  - run rises with S=0: stall is high for exactly 33 enabled cycles (S=0..32).
  - In the cycle where S=33, stall=0 and quot/rem are valid.
  - The CPU captures the results on that edge, then drops run.
- ce=0: S and RQ frozen; stall keeps its current value.
- Inputs x, y and u must be stable from the run rising edge until stall falls. Behaviour with changing inputs is undefined.
- Divide by zero (y=0): no trap. Every step subtracts successfully.
  - Unsigned: quot=0xFFFFFFFF, rem=x.
  - Signed: results follow the same formula; no special casing.
- Abort: run dropping mid-operation clears S on the next enabled edge. The next run starts a fresh division.
- Reset mid-operation: S and RQ clear immediately; stall follows run.
- Back-to-back divisions need run low for at least one enabled edge between them.

Test Plan:
- Unsigned x=100, y=7, u=0, ce=1:
  - stall high for exactly 33 cycles.
  - Then quot=14, rem=2, stall=0 while run stays high.
- Signed x=-7 (0xFFFFFFF9), y=2, u=1: quot=0xFFFFFFFC (-4), rem=1.
- Same operands with u=0: quot=0x7FFFFFFC, rem=1.
- Signed x=-8, y=2: quot=-4, rem=0.
- Divide by zero, x=0x12345678, y=0, u=0: quot=0xFFFFFFFF, rem=0x12345678 after 33 cycles.
- ce toggled 1/0 alternately:
  - stall lasts 66 clocks.
  - Result is identical to the ce=1 case for 1000/10 (quot=100, rem=0).
- run dropped after 10 cycles, then reasserted with x=50, y=5:
  - Full 33-cycle stall.
  - quot=10, rem=0.
- rst pulsed low mid-division: S=0 immediately; a subsequent run yields the correct result.

Source files
------------

// File: rtl/divider.sv
// Sequential 32-bit restoring divider for the execute stage: one quotient bit per enabled
// clock, unsigned or floor-signed (non-negative remainder), holding the pipeline via stall.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        run,
    input  logic        u,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    localparam logic [5:0] LAST_STEP = 6'd33;

    logic [5:0]  s;
    logic [63:0] rq;
    logic        sign;
    logic [31:0] x0;
    logic [32:0] w0;
    logic [31:0] r_mag;
    logic [31:0] q_mag;

    always_comb begin
        sign  = u & x[31];
        x0    = sign ? (~x + 32'd1) : x;
        w0    = {1'b0, rq[62:31]} - {1'b0, y};
        stall = run & (s != LAST_STEP);
        r_mag = rq[63:32];
        q_mag = rq[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s  <= 6'd0;
            rq <= 64'd0;
        end else if (ce) begin
            if (run) begin
                if (s == 6'd0) begin
                    rq <= {32'd0, x0};
                end else if (s != LAST_STEP) begin
                    // w0[32] is the borrow: set means the trial subtraction failed
                    if (w0[32])
                        rq <= {rq[62:0], 1'b0};
                    else
                        rq <= {w0[31:0], rq[30:0], 1'b1};
                end
                if (s != LAST_STEP)
                    s <= s + 6'd1;
            end else begin
                s <= 6'd0;
            end
        end
    end

    // Negative dividend: floor correction turns (q', r') into (-q'-1, y-r') unless exact
    always_comb begin
        quot = q_mag;
        rem  = r_mag;
        if (sign) begin
            if (r_mag == 32'd0) begin
                quot = ~q_mag + 32'd1;
                rem  = 32'd0;
            end else begin
                quot = ~q_mag;
                rem  = y - r_mag;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed testbench for divider: expected quotient/remainder pairs are queued when a
// division starts and compared when stall falls.
module tb_divider;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        run;
    logic        u;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] quot;
    logic [31:0] rem;

    int checks;
    int errors;
    logic [63:0] sb_q[$];

    divider dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .run   (run),
        .u     (u),
        .x     (x),
        .y     (y),
        .stall (stall),
        .quot  (quot),
        .rem   (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Floor-division reference using 64-bit signed arithmetic
    function automatic logic [63:0] model(input logic [31:0] xi, input logic [31:0] yi,
                                          input logic ui);
        longint xs, ys, q, r;
        if (yi == 32'd0)
            return {32'hFFFF_FFFF, xi};
        xs = ui ? longint'($signed(xi)) : longint'({32'd0, xi});
        ys = longint'({32'd0, yi});
        q  = xs / ys;
        r  = xs % ys;
        if (r < 0) begin
            q = q - 1;
            r = r + ys;
        end
        return {q[31:0], r[31:0]};
    endfunction

    task automatic do_div(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                          input logic ui, input bit alt, input int exp_cycles);
        int cnt;
        logic [63:0] exp;
        logic [31:0] q_hold;
        sb_q.push_back(model(xi, yi, ui));
        x   = xi;
        y   = yi;
        u   = ui;
        ce  = alt ? 1'b0 : 1'b1;
        run = 1'b1;
        #1;
        chk({tag, "_stall_rise"}, {63'd0, stall}, 64'd1);
        cnt = 0;
        while (stall && cnt < 300) begin
            cnt++;
            @(posedge clk);
            #1;
            if (alt)
                ce = ~ce;
        end
        ce = 1'b1;
        chk({tag, "_stall_cycles"}, 64'(cnt), 64'(exp_cycles));
        chk({tag, "_sb_nonempty"}, {63'd0, (sb_q.size() != 0)}, 64'd1);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            chk({tag, "_quot"}, {32'd0, quot}, {32'd0, exp[63:32]});
            chk({tag, "_rem"}, {32'd0, rem}, {32'd0, exp[31:0]});
        end
        q_hold = quot;
        @(posedge clk);
        #1;
        chk({tag, "_stall_sat"}, {63'd0, stall}, 64'd0);
        chk({tag, "_quot_hold"}, {32'd0, quot}, {32'd0, q_hold});
        run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        ce  = 1'b1;
        run = 1'b0;
        u   = 1'b0;
        x   = 32'd0;
        y   = 32'd0;
        #1;
        chk("reset_stall", {63'd0, stall}, 64'd0);
        chk("reset_quot", {32'd0, quot}, 64'd0);
        chk("reset_rem", {32'd0, rem}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_div("u100_7", 32'd100, 32'd7, 1'b0, 1'b0, 33);
        chk("const_u100_q", {32'd0, quot}, 64'd14);
        chk("const_u100_r", {32'd0, rem}, 64'd2);
        do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 33);
        chk("const_sm7_q", {32'd0, quot}, 64'h0000_0000_FFFF_FFFC);
        chk("const_sm7_r", {32'd0, rem}, 64'd1);
        do_div("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 33);
        chk("const_uf9_q", {32'd0, quot}, 64'h0000_0000_7FFF_FFFC);
        do_div("s_m8_2", 32'hFFFF_FFF8, 32'd2, 1'b1, 1'b0, 33);
        chk("const_sm8_r", {32'd0, rem}, 64'd0);
        do_div("div0", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 33);
        chk("const_div0_r", {32'd0, rem}, 64'h0000_0000_1234_5678);
        do_div("ce_alt", 32'd1000, 32'd10, 1'b0, 1'b1, 66);
        chk("const_ce_q", {32'd0, quot}, 64'd100);

        // Abort after 10 cycles, then a fresh division
        x = 32'd123; y = 32'd3; u = 1'b0; run = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        run = 1'b0;
        @(posedge clk);
        #1;
        do_div("after_abort", 32'd50, 32'd5, 1'b0, 1'b0, 33);

        // Asynchronous reset mid-division
        x = 32'd1000; y = 32'd7; u = 1'b0; run = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_mid_stall", {63'd0, stall}, 64'd1);
        chk("rst_mid_quot", {32'd0, quot}, 64'd0);
        chk("rst_mid_rem", {32'd0, rem}, 64'd0);
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_div("after_rst", 32'd1000, 32'd7, 1'b0, 1'b0, 33);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] rx, ry;
            rx = $urandom;
            ry = $urandom_range(1, 100000);
            do_div("rand", rx, ry, 1'(i % 2), 1'b0, 33);
        end
        do_div("s_bigy", 32'h8000_0001, 32'hC000_0000, 1'b1, 1'b0, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
